mul_wb_queue: RTL
=================

// Module: mul_wb_queue
// PURPOSE
//  Receiving end of the multiplier pipeline. Captures each instruction leaving the last
//  mul_stage (result, dest reg, PC, exception bundle) into an in-order FIFO and drains it
//  to the writeback arbiter over a valid/ready handshake. When full, it back-pressures the
//  mul pipe with stall_mul_out. Exceptions are carried through and are never resolved here.
// PARAMETERS
//  DEPTH     4   entries; power of two, range 2..16
//  PTR_W     2   $clog2(DEPTH); derived, not overridden
// PORTS
//  clock            in   1   core clock
//  reset            in   1   asynchronous, active-high reset
//  flush_in         in   1   synchronous flush; discards all entries
//  instr_valid_in   in   1   last mul_stage holds a valid instruction
//  instr_id_in      in   3   ROB/instruction tag
//  program_counter_in in 32  PC of the instruction
//  dest_reg_in      in   5   destination register
//  data_result_in   in   32  multiply result
//  xcpt_fetch_in    in   66  fetch exception bundle
//  xcpt_decode_in   in   33  decode exception bundle
//  xcpt_mul_in      in   33  mul exception bundle
//  stall_mul_out    out  1   queue full; mul pipe must hold its last stage
//  wb_valid_out     out  1   head entry presented to writeback
//  wb_ready_in      in   1   writeback accepts the head entry this cycle
//  wb_instr_id_out  out  3   head tag
//  wb_pc_out        out  32  head PC
//  wb_dest_reg_out  out  5   head dest reg
//  wb_data_out      out  32  head result
//  wb_write_rf_out  out  1   head has no exception and dest_reg != 0
//  wb_xcpt_out      out  1   head has any exception valid flag set
//  wb_xcpt_fetch_out  out 66 head fetch bundle
//  wb_xcpt_decode_out out 33 head decode bundle
//  wb_xcpt_mul_out    out 33 head mul bundle
// BEHAVIOUR
//  - Reset (async): rd_ptr = wr_ptr = count = 0. All wb_* outputs 0, stall_mul_out 0.
//    Entry storage is not reset.
//  - Push: instr_valid_in && !stall_mul_out. Writes entry[wr_ptr], wr_ptr++ (mod DEPTH).
//  - Pop: wb_valid_out && wb_ready_in. rd_ptr++ (mod DEPTH).
//  - count: +1 on push only, -1 on pop only, unchanged on both or neither.
//  - stall_mul_out = (count == DEPTH). Taken from registered count; no same-cycle
//    pop bypass. instr_valid_in while stalled is ignored and flagged by a simulation assertion.
//  - Push and pop in the same cycle are allowed whenever 0 < count < DEPTH.
//  - Latency: an entry pushed in cycle N is visible on wb_* in cycle N+1. There is no
//    empty-queue bypass.
//  - wb_valid_out = (count != 0). wb_* show entry[rd_ptr] and stay stable until popped.
//  - Exception-valid flag is the MSB of each 33-bit bundle: fetch bits 65 and 32, decode
//    bit 32, mul bit 32. wb_xcpt_out is the OR of these flags.
//    wb_write_rf_out = wb_valid_out && !wb_xcpt_out && dest != 0.
//  - Ordering: strictly FIFO. instr_id is carried, never re-sorted.
//  - flush_in: the next edge sets pointers and count to 0. It overrides any same-cycle
//    push or pop. Then wb_valid_out = 0 and stall_mul_out = 0.
//  - Pointer wrap: pointers are PTR_W bits wide and wrap naturally. Full and empty are
//    decided by count only.
//  - Reset mid-operation: all entries are lost immediately and the outputs follow the
//    reset values.
// STRUCTURE
//  - core_pkg holds: MUL_WB_DEPTH, the xcpt bundle widths, the xcpt valid-bit index
//    constants, and a mul_wb_entry_t typedef packing id/pc/dest/data/xcpt (204 bits).
//  - One sub-module, sync_fifo_mem: a DEPTH x entry register array with 1 write port and
//    1 async-read port. Control logic stays in mul_wb_queue.
// TESTING
//  1. Reset, then push one entry (id=3, pc=0x100, dest=5, data=0xDEADBEEF) with
//     wb_ready_in=1 -> next cycle wb_valid_out=1 and wb_data_out=0xDEADBEEF;
//     wb_write_rf_out=1; one cycle later wb_valid_out=0.
//  2. wb_ready_in=0, push 4 entries -> stall_mul_out=1 after the 4th. A 5th
//     instr_valid_in is ignored. Then ready=1 drains ids in push order 0,1,2,3.
//  3. count=2, push and pop in the same cycle for 6 cycles -> count stays 2 and wrap-around
//     preserves order. Check all data matches a reference model.
//  4. Push an entry with xcpt_mul_in[32]=1 and dest=7 -> wb_xcpt_out=1 and
//     wb_write_rf_out=0. Push with dest=0 and no xcpt -> wb_write_rf_out=0.
//  5. Queue holds 3 entries; assert flush_in with a simultaneous push -> next cycle
//     wb_valid_out=0 and stall_mul_out=0. A subsequent push appears alone.
//  6. Assert reset asynchronously mid-drain (between clock edges) -> wb_valid_out drops
//     immediately. After release the queue is empty and the next push is accepted.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the multiplier writeback queue: entry layout,
// exception bundle widths and the position of each bundle's valid flag.
package core_pkg;

  localparam int MUL_WB_DEPTH     = 4;
  localparam int XCPT_FETCH_W     = 66;
  localparam int XCPT_DECODE_W    = 33;
  localparam int XCPT_MUL_W       = 33;

  // Each 33-bit exception record carries its valid flag in the MSB;
  // the fetch bundle is two such records back to back.
  localparam int XCPT_FETCH_VLD_HI = 65;
  localparam int XCPT_FETCH_VLD_LO = 32;
  localparam int XCPT_DECODE_VLD   = 32;
  localparam int XCPT_MUL_VLD      = 32;

  typedef struct packed {
    logic [2:0]               instr_id;
    logic [31:0]              pc;
    logic [4:0]               dest_reg;
    logic [31:0]              data;
    logic [XCPT_FETCH_W-1:0]  xcpt_fetch;
    logic [XCPT_DECODE_W-1:0] xcpt_decode;
    logic [XCPT_MUL_W-1:0]    xcpt_mul;
  } mul_wb_entry_t;

  function automatic logic entry_has_xcpt(input mul_wb_entry_t e);
    return e.xcpt_fetch[XCPT_FETCH_VLD_HI] | e.xcpt_fetch[XCPT_FETCH_VLD_LO] |
           e.xcpt_decode[XCPT_DECODE_VLD]  | e.xcpt_mul[XCPT_MUL_VLD];
  endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// Entry storage for the writeback queue: one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module sync_fifo_mem
  import core_pkg::*;
#(
  parameter int DEPTH = MUL_WB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [PTR_W-1:0] i_waddr,
  input  mul_wb_entry_t i_wdata,
  input  logic [PTR_W-1:0] i_raddr,
  output mul_wb_entry_t o_rdata
);

  mul_wb_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mul_wb_queue.sv
// In-order queue between the last multiplier stage and the writeback arbiter.
// Full/empty come from the registered count; exceptions pass through untouched.
module mul_wb_queue
  import core_pkg::*;
#(
  parameter int DEPTH = MUL_WB_DEPTH,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush_in,
  input  logic                     instr_valid_in,
  input  logic [2:0]               instr_id_in,
  input  logic [31:0]              program_counter_in,
  input  logic [4:0]               dest_reg_in,
  input  logic [31:0]              data_result_in,
  input  logic [XCPT_FETCH_W-1:0]  xcpt_fetch_in,
  input  logic [XCPT_DECODE_W-1:0] xcpt_decode_in,
  input  logic [XCPT_MUL_W-1:0]    xcpt_mul_in,
  output logic                     stall_mul_out,
  output logic                     wb_valid_out,
  input  logic                     wb_ready_in,
  output logic [2:0]               wb_instr_id_out,
  output logic [31:0]              wb_pc_out,
  output logic [4:0]               wb_dest_reg_out,
  output logic [31:0]              wb_data_out,
  output logic                     wb_write_rf_out,
  output logic                     wb_xcpt_out,
  output logic [XCPT_FETCH_W-1:0]  wb_xcpt_fetch_out,
  output logic [XCPT_DECODE_W-1:0] wb_xcpt_decode_out,
  output logic [XCPT_MUL_W-1:0]    wb_xcpt_mul_out
);

  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic          w_push;
  logic          w_pop;
  mul_wb_entry_t w_wr_entry;
  mul_wb_entry_t w_head;
  mul_wb_entry_t w_head_vis;

  assign stall_mul_out = (r_count == CNT_W'(DEPTH));
  assign wb_valid_out  = (r_count != '0);
  assign w_push        = instr_valid_in && !stall_mul_out;
  assign w_pop         = wb_valid_out && wb_ready_in;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_in) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_comb begin
    w_wr_entry             = '0;
    w_wr_entry.instr_id    = instr_id_in;
    w_wr_entry.pc          = program_counter_in;
    w_wr_entry.dest_reg    = dest_reg_in;
    w_wr_entry.data        = data_result_in;
    w_wr_entry.xcpt_fetch  = xcpt_fetch_in;
    w_wr_entry.xcpt_decode = xcpt_decode_in;
    w_wr_entry.xcpt_mul    = xcpt_mul_in;
  end

  sync_fifo_mem #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_mem (
    .i_clk   (clock),
    .i_we    (w_push && !flush_in),
    .i_waddr (r_wr_ptr),
    .i_wdata (w_wr_entry),
    .i_raddr (r_rd_ptr),
    .o_rdata (w_head)
  );

  // Storage is never reset, so the head is masked to keep wb_* at zero when empty.
  assign w_head_vis         = wb_valid_out ? w_head : '0;
  assign wb_instr_id_out    = w_head_vis.instr_id;
  assign wb_pc_out          = w_head_vis.pc;
  assign wb_dest_reg_out    = w_head_vis.dest_reg;
  assign wb_data_out        = w_head_vis.data;
  assign wb_xcpt_fetch_out  = w_head_vis.xcpt_fetch;
  assign wb_xcpt_decode_out = w_head_vis.xcpt_decode;
  assign wb_xcpt_mul_out    = w_head_vis.xcpt_mul;
  assign wb_xcpt_out        = entry_has_xcpt(w_head_vis);
  assign wb_write_rf_out    = wb_valid_out && !wb_xcpt_out && (w_head_vis.dest_reg != '0);

  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(instr_valid_in && stall_mul_out))
    else $warning("mul_wb_queue: instr_valid_in while full, instruction dropped");

endmodule
